// File: rtl/te_pkg.sv
//------------------------------------------------------------------------------
// te_pkg : shared state encoding and default sizing for the stage sequencer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package te_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    DREADY  = 3'd2,
    TX1     = 3'd3,
    GAP     = 3'd4,
    TX2     = 3'd5
  } te_state_e;

  localparam int TE_DATA_W_DEF  = 8;
  localparam int TE_GAP_CYC_DEF = 2;

endpackage

`default_nettype wire

// File: rtl/te_shift_cnt.sv
//------------------------------------------------------------------------------
// te_shift_cnt : serial-in word register plus down-counter with terminal count
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module te_shift_cnt #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              din,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_val,
  input  logic              dec,
  output logic              tc,
  output logic              out_bit
);

  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] word_shifted;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;

  generate
    if (DATA_W == 1) begin : g_single_bit
      assign word_shifted = din;
    end else begin : g_multi_bit
      assign word_shifted = {word[DATA_W-2:0], din};
    end
  endgenerate

  always_comb begin
    cnt_next = cnt;
    if (load) begin
      cnt_next = load_val;
    end else if (dec) begin
      cnt_next = cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // The transmit bit is selected by the upcoming count so the caller can
  // register it in the same cycle the count advances; the word never shifts.
  always_comb begin
    out_bit = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (cnt_next == i[CNT_W-1:0]) out_bit = word[i];
    end
  end

  assign tc = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      cnt  <= '0;
    end else begin
      cnt <= cnt_next;
      if (shift_en) word <= word_shifted;
    end
  end

endmodule

`default_nettype wire

// File: rtl/te_stage_sequencer.sv
//------------------------------------------------------------------------------
// te_stage_sequencer : capture a serial word, then replay it on two channels
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module te_stage_sequencer
  import te_pkg::*;
#(
  parameter int DATA_W  = TE_DATA_W_DEF,
  parameter int GAP_CYC = TE_GAP_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic data,
  output logic ready,
  output logic dataReady,
  output logic execute1,
  output logic dataTx1,
  output logic execute2,
  output logic dataTx2,
  output logic start_err
);

  localparam int CNT_W      = $clog2(((DATA_W > GAP_CYC) ? DATA_W : GAP_CYC) + 1);
  localparam int LAST_BIT_I = DATA_W - 1;
  localparam int GAP_LAST_I = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] LAST_BIT = LAST_BIT_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] GAP_LAST = GAP_LAST_I[CNT_W-1:0];

  te_state_e        state;
  logic             shift_en;
  logic             load;
  logic             dec;
  logic [CNT_W-1:0] load_val;
  logic             tc;
  logic             out_bit;

  te_shift_cnt #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shift_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .din      (data),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .tc       (tc),
    .out_bit  (out_bit)
  );

  // Counter holds "cycles left in this state minus one"; tc marks the last one.
  always_comb begin
    shift_en = 1'b0;
    load     = 1'b0;
    dec      = 1'b0;
    load_val = LAST_BIT;
    case (state)
      IDLE:    load = start;
      CAPTURE: begin
        shift_en = 1'b1;
        dec      = !tc;
      end
      DREADY:  load = 1'b1;
      TX1: begin
        if (tc) begin
          load = 1'b1;
          if (GAP_CYC > 0) load_val = GAP_LAST;
        end else begin
          dec = 1'b1;
        end
      end
      GAP: begin
        if (tc) load = 1'b1;
        else    dec  = 1'b1;
      end
      TX2:     dec = !tc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      dataReady <= 1'b0;
      execute1  <= 1'b0;
      dataTx1   <= 1'b0;
      execute2  <= 1'b0;
      dataTx2   <= 1'b0;
      start_err <= 1'b0;
    end else begin
      dataReady <= 1'b0;
      execute1  <= 1'b0;
      dataTx1   <= 1'b0;
      execute2  <= 1'b0;
      dataTx2   <= 1'b0;
      start_err <= start && (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            state <= CAPTURE;
            ready <= 1'b0;
          end
        end
        CAPTURE: begin
          if (tc) begin
            state     <= DREADY;
            dataReady <= 1'b1;
          end
        end
        DREADY: begin
          state    <= TX1;
          execute1 <= 1'b1;
          dataTx1  <= out_bit;
        end
        TX1: begin
          if (!tc) begin
            execute1 <= 1'b1;
            dataTx1  <= out_bit;
          end else if (GAP_CYC > 0) begin
            state <= GAP;
          end else begin
            state    <= TX2;
            execute2 <= 1'b1;
            dataTx2  <= out_bit;
          end
        end
        GAP: begin
          if (tc) begin
            state    <= TX2;
            execute2 <= 1'b1;
            dataTx2  <= out_bit;
          end
        end
        TX2: begin
          if (!tc) begin
            execute2 <= 1'b1;
            dataTx2  <= out_bit;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_te_stage_sequencer.sv
//------------------------------------------------------------------------------
// tb_te_stage_sequencer : table-driven check of three sequencer configurations
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_te_stage_sequencer;

  logic       clk;
  logic       rst_n;
  logic [2:0] st, dt;
  logic [2:0] rdy, drd, e1, t1, e2, t2, err;

  int checks = 0;
  int errors = 0;

  // Entry i: inputs applied at edge i, expected outputs in the cycle after it.
  // exp = {ready, dataReady, execute1, dataTx1, execute2, dataTx2, start_err}
  typedef struct {
    logic       start;
    logic       data;
    logic [6:0] exp;
  } vec_t;

  vec_t q0[$];
  vec_t q1[$];
  vec_t q2[$];

  localparam logic [6:0] RST_VEC = 7'b1000000;

  te_stage_sequencer u_def (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .data(dt[0]),
    .ready(rdy[0]), .dataReady(drd[0]), .execute1(e1[0]), .dataTx1(t1[0]),
    .execute2(e2[0]), .dataTx2(t2[0]), .start_err(err[0])
  );

  te_stage_sequencer #(.DATA_W(8), .GAP_CYC(0)) u_gap0 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .data(dt[1]),
    .ready(rdy[1]), .dataReady(drd[1]), .execute1(e1[1]), .dataTx1(t1[1]),
    .execute2(e2[1]), .dataTx2(t2[1]), .start_err(err[1])
  );

  te_stage_sequencer #(.DATA_W(1), .GAP_CYC(2)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .data(dt[2]),
    .ready(rdy[2]), .dataReady(drd[2]), .execute1(e1[2]), .dataTx1(t1[2]),
    .execute2(e2[2]), .dataTx2(t2[2]), .start_err(err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outv(int d);
    return {rdy[d], drd[d], e1[d], t1[d], e2[d], t2[d], err[d]};
  endfunction

  // Expected {ready,dataReady,ex1,tx1,ex2,tx2} in cycle r after start (r >= 1).
  function automatic logic [5:0] txn(int r, logic [7:0] w, int W, int G);
    int k;
    if (r <= W) return 6'b000000;
    if (r == W + 1) return 6'b010000;
    if (r <= 2 * W + 1) begin
      k = r - W - 2;
      return {3'b001, w[W-1-k], 2'b00};
    end
    if (r <= 2 * W + 1 + G) return 6'b000000;
    if (r <= 3 * W + 1 + G) begin
      k = r - 2 * W - 2 - G;
      return {5'b00001, w[W-1-k]};
    end
    return 6'b100000;
  endfunction

  // start_err is expected whenever start was driven while the DUT was busy.
  task automatic add(int d, logic s, logic dv, logic [5:0] base);
    vec_t v;
    logic prev_rdy;
    prev_rdy = 1'b1;
    case (d)
      0: if (q0.size() > 0) prev_rdy = q0[q0.size()-1].exp[6];
      1: if (q1.size() > 0) prev_rdy = q1[q1.size()-1].exp[6];
      default: if (q2.size() > 0) prev_rdy = q2[q2.size()-1].exp[6];
    endcase
    v.start = s;
    v.data  = dv;
    v.exp   = {base, s & ~prev_rdy};
    case (d)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic chk(string name, int d, int cyc, logic [6:0] act, logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: actual=%b required=%b", name, d, cyc, act, exp);
    end
  endtask

  task automatic run_tables(string name);
    int n;
    n = q0.size();
    if (q1.size() > n) n = q1.size();
    if (q2.size() > n) n = q2.size();
    for (int i = 0; i < n; i++) begin
      st[0] = (i < q0.size()) ? q0[i].start : 1'b0;
      dt[0] = (i < q0.size()) ? q0[i].data  : 1'b0;
      st[1] = (i < q1.size()) ? q1[i].start : 1'b0;
      dt[1] = (i < q1.size()) ? q1[i].data  : 1'b0;
      st[2] = (i < q2.size()) ? q2[i].start : 1'b0;
      dt[2] = (i < q2.size()) ? q2[i].data  : 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (i < q0.size()) chk(name, 0, i + 1, outv(0), q0[i].exp);
      if (i < q1.size()) chk(name, 1, i + 1, outv(1), q1[i].exp);
      if (i < q2.size()) chk(name, 2, i + 1, outv(2), q2[i].exp);
    end
    st = '0;
    dt = '0;
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  initial begin
    logic [7:0] wa, wb, wc;
    rst_n = 1'b0;
    st    = '0;
    dt    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk("reset", d, 0, outv(d), RST_VEC);
    rst_n = 1'b1;

    // Single transactions; default DUT also gets a stray start during TX1.
    wa = 8'hA5;
    for (int i = 0; i < 30; i++) begin
      add(0, (i == 0) || (i == 12), (i >= 1 && i <= 8) ? wa[8-i] : 1'b1, txn(i + 1, wa, 8, 2));
      add(1, i == 0, (i >= 1 && i <= 8), txn(i + 1, 8'hFF, 8, 0));
      add(2, i == 0, i == 1, txn(i + 1, 8'h01, 1, 2));
    end
    run_tables("single");

    // start held high: back-to-back transactions with a one-cycle ready window.
    wb = 8'h3C;
    wc = 8'hC3;
    for (int i = 0; i < 57; i++) begin
      add(0, i < 56,
          (i >= 1 && i <= 8) ? wb[8-i] : ((i >= 29 && i <= 36) ? wc[36-i] : 1'b0),
          (i + 1 <= 28) ? txn(i + 1, wb, 8, 2) : txn(i + 1 - 28, wc, 8, 2));
    end
    for (int i = 0; i < 14; i++) begin
      add(2, i < 13, i == 8,
          (i + 1 <= 7) ? txn(i + 1, 8'h00, 1, 2) : txn(i + 1 - 7, 8'h01, 1, 2));
    end
    run_tables("held");

    // Asynchronous reset in the middle of TX1 discards the transaction.
    for (int i = 0; i < 13; i++) begin
      add(0, i == 0, (i >= 1 && i <= 8) ? wa[8-i] : 1'b0, txn(i + 1, wa, 8, 2));
    end
    run_tables("pre_reset");
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk("async_reset", d, 14, outv(d), RST_VEC);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_held", 0, 16, outv(0), RST_VEC);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      dt = 3'($urandom_range(0, 7));
      @(posedge clk);
      @(negedge clk);
      chk("post_reset", 0, i, outv(0), RST_VEC);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
